// File: rtl/lane_serializer_pkg.sv
// rtl/lane_serializer_pkg.sv - shared util macros, log2 and FSM types for the lane serializer
`ifndef LANE_UTIL_MACROS
`define LANE_UTIL_MACROS
`define UNPACK_ARRAY(PK_WIDTH, PK_LEN, PK_DEST, PK_SRC) \
  for (genvar unpk_idx = 0; unpk_idx < (PK_LEN); unpk_idx++) begin \
    assign PK_DEST[unpk_idx] = PK_SRC[(PK_WIDTH)*unpk_idx +: (PK_WIDTH)]; \
  end
`define PACK_ARRAY(PK_WIDTH, PK_LEN, PK_SRC, PK_DEST) \
  for (genvar pk_idx = 0; pk_idx < (PK_LEN); pk_idx++) begin \
    assign PK_DEST[(PK_WIDTH)*pk_idx +: (PK_WIDTH)] = PK_SRC[pk_idx]; \
  end
`endif

package lane_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Ceiling log2; LANES is a power of two so this is exact for our use.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_prienc.sv
// rtl/lane_prienc.sv - lowest-set-bit encoder with single-bit (last) detect
module lane_prienc
  import lane_serializer_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LW    = log2(LANES)
) (
  input  logic [LANES-1:0] mask,
  output logic [LW-1:0]    idx,
  output logic             any,
  output logic             last
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = LW'(i);
        any = 1'b1;
      end
    end
    // The lowest set bit is also the last one when it is the only one.
    last = any && ((mask & (mask - LANES'(1))) == '0);
  end

endmodule

// File: rtl/lane_serializer.sv
// rtl/lane_serializer.sv - serializes the active lanes of a packed vector, lowest lane first
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  localparam int LW   = log2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] pack_in,
  input  logic [LANES-1:0]       in_mask,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [LW-1:0]          out_lane,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  state_t state;
  state_t state_nxt;

  logic [LANES*WIDTH-1:0] cap_data;
  logic [LANES-1:0]       cap_mask;
  logic [WIDTH-1:0]       cap_lanes [LANES];
  logic [WIDTH-1:0]       in_lanes  [LANES];

  logic [LANES-1:0] nxt_mask;
  logic [LW-1:0]    in_idx;
  logic             in_any;
  logic             in_last;
  logic [LW-1:0]    nxt_idx;
  logic             nxt_any;
  logic             nxt_last;
  logic             accept;
  logic             xfer;

  `UNPACK_ARRAY(WIDTH, LANES, cap_lanes, cap_data)
  `UNPACK_ARRAY(WIDTH, LANES, in_lanes, pack_in)

  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign nxt_mask = cap_mask & ~(LANES'(1) << out_lane);

  lane_prienc #(.LANES(LANES), .LW(LW)) u_in_enc (
    .mask (in_mask),
    .idx  (in_idx),
    .any  (in_any),
    .last (in_last)
  );

  lane_prienc #(.LANES(LANES), .LW(LW)) u_nxt_enc (
    .mask (nxt_mask),
    .idx  (nxt_idx),
    .any  (nxt_any),
    .last (nxt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)                state_nxt = in_any ? ST_SEND : ST_IDLE;
    else if (xfer && out_last) state_nxt = ST_IDLE;
  end

  // in_ready opens during the last transfer so the next vector follows without a bubble.
  always_comb begin
    in_ready = (state == ST_IDLE) || (out_valid && out_last && out_ready);
    busy     = (state == ST_SEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data  <= '0;
      cap_mask  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      cap_data  <= pack_in;
      cap_mask  <= in_mask;
      out_valid <= in_any;
      out_data  <= in_lanes[in_idx];
      out_lane  <= in_idx;
      out_last  <= in_last;
    end else if (xfer) begin
      if (out_last) begin
        cap_mask  <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        cap_mask  <= nxt_mask;
        out_valid <= nxt_any;
        out_data  <= cap_lanes[nxt_idx];
        out_lane  <= nxt_idx;
        out_last  <= nxt_last;
      end
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// tb/tb_lane_serializer.sv - scoreboard bench for lane_serializer
module tb_lane_serializer;

  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int LW    = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [LANES*WIDTH-1:0] pack_in = '0;
  logic [LANES-1:0]       in_mask = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [WIDTH-1:0]       out_data;
  logic [LW-1:0]          out_lane;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic                   out_last;
  logic                   busy;

  typedef struct packed {
    logic [LW-1:0]    lane;
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ready_mode = 0;
  logic hold_v = 1'b0;
  logic [19:0] held = '0;

  lane_serializer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pack_in   (pack_in),
    .in_mask   (in_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [LANES*WIDTH-1:0] rand_vec();
    logic [LANES*WIDTH-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  // Reference: every set lane, in ascending order, last flag on the highest set lane.
  function automatic void model_push(input logic [LANES*WIDTH-1:0] v, input logic [LANES-1:0] m);
    int   hi;
    exp_t e;
    hi = -1;
    for (int i = 0; i < LANES; i++) if (m[i]) hi = i;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        e.lane = LW'(i);
        e.data = v[i*WIDTH +: WIDTH];
        e.last = (i == hi);
        exp_q.push_back(e);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) exp_q.delete();
    else if (in_valid && in_ready) model_push(pack_in, in_mask);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      chk("valid_outside_send", 32'(out_valid && !busy), 32'(0));
      if (hold_v) chk("hold_stable", 32'({out_valid, out_data, out_lane, out_last}), 32'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got lane %0d data %0h, expected none at %0t",
                   out_lane, out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_elem", 32'({out_lane, out_data, out_last}), 32'({e.lane, e.data, e.last}));
        end
      end
      hold_v = out_valid && !out_ready;
      held   = {out_valid, out_data, out_lane, out_last};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [LANES-1:0] m, input logic [LANES*WIDTH-1:0] v,
                      output logic last_at_acc);
    int   t;
    logic ok;
    t = 0;
    ok = 1'b0;
    last_at_acc = 1'b0;
    in_valid = 1'b1;
    in_mask  = m;
    pack_in  = v;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        last_at_acc = out_valid && out_last;
      end
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    in_mask  = LANES'($urandom);
    pack_in  = rand_vec();
    if (!ok) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(exp_q.size() == 0 && !out_valid) && t < bound);
    chk("drain", 32'(exp_q.size() == 0 && !out_valid), 32'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [LANES*WIDTH-1:0] v;
    logic la;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_lane", 32'(out_lane), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));
    chk("post_rst_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;

    // Full mask, consecutive transfers, idle afterwards.
    v = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    send(4'b1111, v, la);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_valid", 32'(out_valid), 32'(1));
      chk("full_lane", 32'(out_lane), 32'(i));
    end
    @(negedge clk);
    chk("full_end_valid", 32'(out_valid), 32'(0));
    chk("full_end_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;

    send(4'b1010, rand_vec(), la);
    wait_idle(20);

    // Empty mask is dropped.
    send(4'b0000, rand_vec(), la);
    @(negedge clk);
    chk("empty_out_valid", 32'(out_valid), 32'(0));
    chk("empty_in_ready", 32'(in_ready), 32'(1));
    chk("empty_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;

    // Backpressure holds lane 0.
    ready_mode = 2;
    out_ready  = 1'b0;
    v = rand_vec();
    send(4'b0101, v, la);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'(1));
      chk("stall_lane", 32'(out_lane), 32'(0));
      chk("stall_data", 32'(out_data), 32'(v[WIDTH-1:0]));
      chk("stall_in_ready", 32'(in_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    ready_mode = 0;
    out_ready  = 1'b1;
    wait_idle(20);

    // Back-to-back: second vector accepted during the last transfer of the first.
    send(4'b0011, rand_vec(), la);
    v = rand_vec();
    v[WIDTH-1:0] = 16'h1234;
    send(4'b0001, v, la);
    chk("b2b_accept_on_last", 32'(la), 32'(1));
    @(negedge clk);
    chk("b2b_valid", 32'(out_valid), 32'(1));
    chk("b2b_data", 32'(out_data), 32'(16'h1234));
    chk("b2b_lane", 32'(out_lane), 32'(0));
    @(posedge clk);
    #1;
    wait_idle(20);

    // Reset after the first of four transfers.
    send(4'b1111, rand_vec(), la);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_out_data", 32'(out_data), 32'(0));
    chk("midrst_out_lane", 32'(out_lane), 32'(0));
    chk("midrst_out_last", 32'(out_last), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_midrst_quiet", 32'(out_valid), 32'(0));
    end
    @(posedge clk);
    #1;

    // Random vectors under random backpressure and idle gaps.
    ready_mode = 1;
    for (int n = 0; n < 150; n++) begin
      send(LANES'($urandom), rand_vec(), la);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        in_mask = LANES'($urandom);
        pack_in = rand_vec();
      end
    end
    ready_mode = 0;
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
LANE_SERIALIZER -- requirements
Module: lane_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bit width of one lane element.
REQ-002 The block SHALL have parameter LANES, default 4, giving the lane count (power of two, at least 2); LW = log2(LANES) using the shared log2 function.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port pack_in, input, LANES*WIDTH, the packed lane vector; lane i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-006 The block SHALL have port in_mask, input, LANES, active-lane mask; bit i set means lane i is emitted.
REQ-007 The block SHALL have port in_valid, input, 1, meaning pack_in/in_mask are valid.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts a vector this cycle.
REQ-009 The block SHALL have port out_data, output, WIDTH, the current lane element.
REQ-010 The block SHALL have port out_lane, output, LW, the index of the current lane.
REQ-011 The block SHALL have port out_valid, output, 1, meaning out_data/out_lane/out_last are valid.
REQ-012 The block SHALL have port out_ready, input, 1, the downstream accept.
REQ-013 The block SHALL have port out_last, output, 1, meaning the current element is the final active lane of the vector.
REQ-014 The block SHALL have port busy, output, 1, high while in state SEND.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and SEND.
REQ-016 Input handshake: accept occurs when in_valid && in_ready on a rising edge; output handshake: transfer occurs when out_valid && out_ready.
REQ-017 in_ready SHALL be 1 in IDLE, and 1 in SEND only when out_valid && out_last && out_ready (combinational), so back-to-back vectors are accepted without a bubble.
REQ-018 On accept with in_mask != 0, the block SHALL capture pack_in and in_mask, enter or stay in SEND, and on the next cycle present the lowest set lane: out_valid=1, out_lane=that index, out_data=its element (latency 1 cycle).
REQ-019 On accept with in_mask == 0, the block SHALL drop the vector, emit nothing, and end in IDLE with out_valid=0.
REQ-020 On each output transfer that is not last, the block SHALL clear that lane's bit in the remaining mask and present the next higher set lane on the following cycle.
REQ-021 out_last SHALL be 1 exactly when no set bit remains above out_lane in the remaining mask.
REQ-022 On a last transfer without a simultaneous accept, the block SHALL return to IDLE with out_valid=0 on the next cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_lane and out_last SHALL hold stable.
REQ-024 out_valid SHALL never be asserted in IDLE; busy SHALL equal (state == SEND).
REQ-025 in_mask bits and pack_in changes while not accepted SHALL have no effect.
REQ-026 A vector with k set mask bits SHALL produce exactly k transfers in ascending lane order, taking k cycles when out_ready is held high.
REQ-027 All outputs except in_ready SHALL be driven from registers.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with out_valid=0, out_data=0, out_lane=0, out_last=0, busy=0, and captured data/mask=0; in_ready SHALL be 1 once rst_n=1.
REQ-029 Reset asserted mid-vector SHALL discard remaining lanes; no element SHALL be emitted after rst_n rises until a new accept occurs.

Structure
REQ-030 The log2 function and the pack/unpack-array macros SHALL come from the shared util header; no local redefinition is permitted.
REQ-031 Lowest-set-bit selection SHALL be a sub-module lane_prienc (inputs mask[LANES]; outputs idx[LW], any, last) used by the serializer.
REQ-032 The captured vector SHALL be unpacked internally into a WIDTH x LANES array using UNPACK_ARRAY.

Verification
REQ-033 Reset, then accept mask=4'b1111 with lanes 0..3 = 16'h000A, 000B, 000C, 000D and out_ready=1 -> 4 transfers on consecutive cycles, out_lane 0,1,2,3, out_last only on lane 3, then IDLE.
REQ-034 Accept mask=4'b1010 -> transfers lane 1 then lane 3 (out_last=1); lanes 0 and 2 never appear.
REQ-035 Accept mask=4'b0000 -> no out_valid, and in_ready stays 1 the following cycle.
REQ-036 Accept mask=4'b0101, hold out_ready=0 for 3 cycles -> lane 0 data held stable and in_ready=0; release -> lane 0 then lane 2.
REQ-037 Back-to-back accept: second vector (mask=4'b0001, lane 0 = 16'h1234) offered during the last transfer of the first -> in_ready=1 that cycle, and 16'h1234 appears on the next cycle with no bubble.
REQ-038 Assert rst_n=0 after the first of 4 transfers -> all outputs reset immediately, and no further transfers occur after release.
